// File: rtl/vga_scan_out.sv
// Raster timing generator and registered VGA DAC output stage.
// Produces DrawX/DrawY for the colour mapper, registers the mapper's RGB one
// pixel later together with sync/blank, and strobes once per frame.
module vga_scan_out #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_en,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST  = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST  = VS_START + V_SYNC - 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pe_q, pe_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic [COL_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic             hs_q, hs_d, vs_q, vs_d, bn_q, bn_d;
  logic             fs_q, fs_d;
  logic             hs_raw_c, vs_raw_c, vis_c;

  // Raw sync/visible decode of the current scan position.
  always_comb begin
    hs_raw_c = !((hc_q >= CNT_W'(HS_START)) && (hc_q <= CNT_W'(HS_LAST)));
    vs_raw_c = !((vc_q >= CNT_W'(VS_START)) && (vc_q <= CNT_W'(VS_LAST)));
    vis_c    = (hc_q < CNT_W'(H_VISIBLE)) && (vc_q < CNT_W'(V_VISIBLE));
  end

  // Next-state: pixel divider, scan counters and the pixel-rate output stage.
  always_comb begin
    div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    pe_d  = (div_q == DIV_W'(CLK_DIV - 1));
    hc_d  = hc_q;
    vc_d  = vc_q;
    r_d   = r_q;
    g_d   = g_q;
    b_d   = b_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    bn_d  = bn_q;
    fs_d  = pe_q && (hc_q == '0) && (vc_q == CNT_W'(V_VISIBLE));
    if (pe_q) begin
      if (hc_q == CNT_W'(H_TOTAL - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == CNT_W'(V_TOTAL - 1)) ? '0 : vc_q + CNT_W'(1);
      end else begin
        hc_d = hc_q + CNT_W'(1);
      end
      hs_d = hs_raw_c;
      vs_d = vs_raw_c;
      bn_d = vis_c;
      r_d  = vis_c ? Red_in   : '0;
      g_d  = vis_c ? Green_in : '0;
      b_d  = vis_c ? Blue_in  : '0;
    end
  end

  // State registers; reset parks the scan at (0,0) with syncs idle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q <= '0;
      pe_q  <= 1'b0;
      hc_q  <= '0;
      vc_q  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      bn_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      pe_q  <= pe_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      bn_q  <= bn_d;
      fs_q  <= fs_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign pixel_en    = pe_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = bn_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out using a shrunken raster (30x17 totals) so that
// several full frames fit in a short run.
module tb_vga_scan_out;

  localparam int unsigned D  = 2;
  localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;   // 30
  localparam int unsigned VT = VV + VF + VS + VB;   // 17

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] red, green, blue;
  logic [9:0] DrawX, DrawY;
  logic       pixel_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  // Stand-in colour mapper: coordinate pattern or solid white.
  assign red   = mode ? 8'hFF : DrawX[7:0];
  assign green = mode ? 8'hFF : DrawY[7:0];
  assign blue  = mode ? 8'hFF : 8'hA5;

  vga_scan_out #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red_in(red), .Green_in(green), .Blue_in(blue),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_en(pixel_en),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .frame_start(frame_start)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pe;
    logic [9:0] dx;
    logic [9:0] dy;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
    logic       fs;
  } obs_t;

  int   vectors = 0;
  int   errors  = 0;
  int   k = 0;
  logic sb_on = 1'b0;
  obs_t exp_q[$];

  function automatic obs_t reset_obs();
    obs_t e;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  // Reference raster: state after k clock edges since reset release.
  function automatic obs_t exp_at(int kk, logic md);
    obs_t e;
    int   n, m, mh, mv;
    logic vis;
    e = reset_obs();
    if (kk == 0) return e;
    n    = (kk - 1) / D;
    e.dx = 10'(n % HT);
    e.dy = 10'((n / HT) % VT);
    e.pe = ((kk % D) == 0);
    if (n > 0) begin
      m    = n - 1;
      mh   = m % HT;
      mv   = (m / HT) % VT;
      vis  = (mh < HV) && (mv < VV);
      e.hs = !((mh >= HV + HF) && (mh < HV + HF + HS));
      e.vs = !((mv >= VV + VF) && (mv < VV + VF + VS));
      e.bn = vis;
      if (vis) begin
        e.r = md ? 8'hFF : 8'(mh);
        e.g = md ? 8'hFF : 8'(mv);
        e.b = md ? 8'hFF : 8'hA5;
      end
      e.fs = (((kk - 1) % D) == 0) && (mh == 0) && (mv == VV);
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.pe = pixel_en; a.dx = DrawX; a.dy = DrawY;
    a.r  = VGA_R;    a.g  = VGA_G; a.b  = VGA_B;
    a.hs = VGA_HS;   a.vs = VGA_VS; a.bn = VGA_BLANK_N;
    a.sn = VGA_SYNC_N; a.fs = frame_start;
    return a;
  endfunction

  task automatic compare(input string name, input obs_t a, input obs_t e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got pe=%b x=%0d y=%0d rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b fs=%b exp pe=%b x=%0d y=%0d rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b fs=%b",
               name, $time, a.pe, a.dx, a.dy, a.r, a.g, a.b, a.hs, a.vs, a.bn, a.sn, a.fs,
               e.pe, e.dx, e.dy, e.r, e.g, e.b, e.hs, e.vs, e.bn, e.sn, e.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Stimulus side of the scoreboard: push the expected state for each edge.
  always @(posedge Clk) begin
    if (!Reset_n) k = 0;
    else          k = k + 1;
    if (sb_on) exp_q.push_back(exp_at(k, mode));
  end

  // Monitor side: pop and compare away from the active edge.
  always @(negedge Clk) begin
    obs_t e;
    if (sb_on) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL scoreboard_empty at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (!Reset_n) e = reset_obs();
        compare("scan", sample(), e);
      end
    end
  end

  // Edges from reset release to the first frame_start: pixel (0,VV) loads
  // on edge D*(VV*HT+1)+1.
  task automatic check_release_to_frame(input string name);
    int cnt;
    cnt = 0;
    do begin
      @(negedge Clk);
      cnt++;
    end while (!frame_start && cnt < 3000);
    check_int(name, cnt, D * (VV * HT + 1) + 1);
  endtask

  // Accumulate one frame period starting at a frame_start sample.
  task automatic measure_frame(input string tag);
    int total, hs_lo, vs_lo, bn_hi, nz, bad;
    total = 0; hs_lo = 0; vs_lo = 0; bn_hi = 0; nz = 0; bad = 0;
    forever begin
      total++;
      if (!VGA_HS) hs_lo++;
      if (!VGA_VS) vs_lo++;
      if (VGA_BLANK_N) bn_hi++;
      if ((VGA_R | VGA_G | VGA_B) != 8'h00) begin
        nz++;
        if (!VGA_BLANK_N) bad++;
      end
      @(negedge Clk);
      if (frame_start || total >= 3000) break;
    end
    check_int({tag, "_frame_clks"}, total, 1020);
    check_int({tag, "_hs_low_clks"}, hs_lo, 204);
    check_int({tag, "_vs_low_clks"}, vs_lo, 120);
    check_int({tag, "_blank_n_clks"}, bn_hi, 320);
    check_int({tag, "_rgb_nonzero_clks"}, nz, 320);
    check_int({tag, "_rgb_in_blank"}, bad, 0);
  endtask

  initial begin
    int cnt;
    sb_on = 1'b1;
    repeat (3) @(negedge Clk);
    #1 compare("reset_hold", sample(), reset_obs());
    #1 Reset_n = 1'b1;

    check_release_to_frame("release_to_frame_start");
    measure_frame("pattern");
    mode = 1'b1;
    measure_frame("white");

    cnt = 0;
    while (!(DrawX == 10'd10 && DrawY == 10'd5) && cnt < 3000) begin
      @(negedge Clk);
      cnt++;
    end
    check_int("reach_mid_frame", (cnt < 3000) ? 1 : 0, 1);
    #2 Reset_n = 1'b0;
    #1 compare("async_reset", sample(), reset_obs());
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b1;
    check_release_to_frame("restart_to_frame_start");

    repeat (40) @(negedge Clk);
    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
